// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Registered RV32I + Zicsr instruction-decode stage between IF
//               and EX. Decodes, builds immediates, selects operands with
//               write-back bypass, detects load-use hazards, holds one decoded
//               instruction under valid/ready and counts hazard stall cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
  parameter int XLEN   = 32,
  parameter int PC_W   = 32,
  parameter int REG_AW = 5,
  parameter int CSR_AW = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_valid_i,
  output logic              if_ready_o,
  input  logic [31:0]       if_inst_i,
  input  logic [PC_W-1:0]   if_pc_i,
  input  logic              flush_i,
  output logic [REG_AW-1:0] reg1_raddr_o,
  output logic [REG_AW-1:0] reg2_raddr_o,
  input  logic [XLEN-1:0]   reg1_rdata_i,
  input  logic [XLEN-1:0]   reg2_rdata_i,
  output logic [CSR_AW-1:0] csr_raddr_o,
  input  logic [XLEN-1:0]   csr_rdata_i,
  input  logic              wb_wen_i,
  input  logic [REG_AW-1:0] wb_waddr_i,
  input  logic [XLEN-1:0]   wb_wdata_i,
  input  logic              ex_load_valid_i,
  input  logic [REG_AW-1:0] ex_load_rd_i,
  output logic              ex_valid_o,
  input  logic              ex_ready_i,
  output logic [XLEN-1:0]   op1_o,
  output logic [XLEN-1:0]   op2_o,
  output logic [XLEN-1:0]   imm_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [31:0]       inst_o,
  output logic [REG_AW-1:0] rd_o,
  output logic              reg_wen_o,
  output logic [CSR_AW-1:0] csr_waddr_o,
  output logic              csr_wen_o,
  output logic              is_load_o,
  output logic              is_store_o,
  output logic              is_branch_o,
  output logic              is_jump_o,
  output logic              is_system_o,
  output logic              illegal_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] C_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] C_OPC_IMM    = 7'b0010011;
  localparam logic [6:0] C_OPC_REG    = 7'b0110011;
  localparam logic [6:0] C_OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] C_OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] C_OP1_ZERO = 2'd0, C_OP1_RS1 = 2'd1, C_OP1_PC = 2'd2, C_OP1_ZIMM = 2'd3;
  localparam logic [1:0] C_OP2_ZERO = 2'd0, C_OP2_RS2 = 2'd1, C_OP2_IMM = 2'd2, C_OP2_CSR = 2'd3;
  localparam logic [2:0] C_IMM_NONE = 3'd0, C_IMM_I = 3'd1, C_IMM_S = 3'd2,
                         C_IMM_B = 3'd3, C_IMM_U = 3'd4, C_IMM_J = 3'd5;

  localparam logic [0:0] C_ST_EMPTY = 1'b0;
  localparam logic [0:0] C_ST_FULL  = 1'b1;

  localparam int C_PAY_W = 3*XLEN + PC_W + 32 + REG_AW + CSR_AW + 8;

  // Instruction fields
  logic [6:0]        w_opc;
  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  logic [REG_AW-1:0] w_rs1, w_rs2, w_rd;
  assign w_opc = if_inst_i[6:0];
  assign w_f3  = if_inst_i[14:12];
  assign w_f7  = if_inst_i[31:25];
  assign w_rs1 = REG_AW'(if_inst_i[19:15]);
  assign w_rs2 = REG_AW'(if_inst_i[24:20]);
  assign w_rd  = REG_AW'(if_inst_i[11:7]);

  logic w_uses_rs1, w_uses_rs2, w_wr_rd, w_is_csr, w_illegal;
  logic w_is_load, w_is_store, w_is_branch, w_is_jump, w_is_system;
  logic [1:0] w_op1_sel, w_op2_sel;
  logic [2:0] w_imm_sel;

  // Control decode: depends only on the instruction word
  always_comb begin
    w_uses_rs1 = 1'b0; w_uses_rs2 = 1'b0; w_wr_rd = 1'b0; w_is_csr = 1'b0;
    w_illegal = 1'b0; w_is_load = 1'b0; w_is_store = 1'b0; w_is_branch = 1'b0;
    w_is_jump = 1'b0; w_is_system = 1'b0;
    w_op1_sel = C_OP1_ZERO; w_op2_sel = C_OP2_ZERO; w_imm_sel = C_IMM_NONE;
    case (w_opc)
      C_OPC_LUI: begin
        w_wr_rd = 1'b1; w_op2_sel = C_OP2_IMM; w_imm_sel = C_IMM_U;
      end
      C_OPC_AUIPC: begin
        w_wr_rd = 1'b1; w_op1_sel = C_OP1_PC; w_op2_sel = C_OP2_IMM; w_imm_sel = C_IMM_U;
      end
      C_OPC_JAL: begin
        w_wr_rd = 1'b1; w_is_jump = 1'b1;
        w_op1_sel = C_OP1_PC; w_op2_sel = C_OP2_IMM; w_imm_sel = C_IMM_J;
      end
      C_OPC_JALR: begin
        w_uses_rs1 = 1'b1; w_wr_rd = 1'b1; w_is_jump = 1'b1;
        w_op1_sel = C_OP1_RS1; w_op2_sel = C_OP2_IMM; w_imm_sel = C_IMM_I;
        w_illegal = (w_f3 != 3'b000);
      end
      C_OPC_BRANCH: begin
        w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; w_is_branch = 1'b1;
        w_op1_sel = C_OP1_RS1; w_op2_sel = C_OP2_RS2; w_imm_sel = C_IMM_B;
        w_illegal = (w_f3[2:1] == 2'b01);
      end
      C_OPC_LOAD: begin
        w_uses_rs1 = 1'b1; w_wr_rd = 1'b1; w_is_load = 1'b1;
        w_op1_sel = C_OP1_RS1; w_op2_sel = C_OP2_IMM; w_imm_sel = C_IMM_I;
        w_illegal = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11);
      end
      C_OPC_STORE: begin
        w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; w_is_store = 1'b1;
        w_op1_sel = C_OP1_RS1; w_op2_sel = C_OP2_RS2; w_imm_sel = C_IMM_S;
        w_illegal = (w_f3 > 3'd2);
      end
      C_OPC_IMM: begin
        w_uses_rs1 = 1'b1; w_wr_rd = 1'b1;
        w_op1_sel = C_OP1_RS1; w_op2_sel = C_OP2_IMM; w_imm_sel = C_IMM_I;
        w_illegal = ((w_f3 == 3'b001) && (w_f7 != 7'h00)) ||
                    ((w_f3 == 3'b101) && (w_f7 != 7'h00) && (w_f7 != 7'h20));
      end
      C_OPC_REG: begin
        w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; w_wr_rd = 1'b1;
        w_op1_sel = C_OP1_RS1; w_op2_sel = C_OP2_RS2;
        // Only ADD/SRL have an alternate (SUB/SRA) encoding with func7 = 0x20
        w_illegal = !((w_f7 == 7'h00) ||
                      ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
      end
      C_OPC_FENCE: ;
      C_OPC_SYSTEM: begin
        if (w_f3 == 3'b000) begin
          w_is_system = 1'b1;
        end else if (w_f3 == 3'b100) begin
          w_illegal = 1'b1;
        end else begin
          // CSR ops: func3[2] selects the zimm variants
          w_is_csr = 1'b1; w_wr_rd = 1'b1; w_uses_rs1 = !w_f3[2];
          w_op1_sel = w_f3[2] ? C_OP1_ZIMM : C_OP1_RS1; w_op2_sel = C_OP2_CSR;
        end
      end
      default: w_illegal = 1'b1;
    endcase
    if (if_inst_i[1:0] != 2'b11) w_illegal = 1'b1;
  end

  assign reg1_raddr_o = w_uses_rs1 ? w_rs1 : '0;
  assign reg2_raddr_o = w_uses_rs2 ? w_rs2 : '0;
  assign csr_raddr_o  = w_is_csr ? CSR_AW'(if_inst_i[31:20]) : '0;

  logic w_reg_wen, w_csr_wen;
  assign w_reg_wen = w_wr_rd && (w_rd != '0) && !w_illegal;
  // Set/clear with a zero source is a pure read and must not write the CSR
  assign w_csr_wen = w_is_csr && !w_illegal && ((w_f3[1:0] == 2'b01) || (if_inst_i[19:15] != 5'd0));

  logic [XLEN-1:0] w_rs1_data, w_rs2_data, w_imm, w_op1, w_op2;
  logic [31:0]     w_imm32;

  // Operand path: bypass, immediate formatting and operand muxes
  always_comb begin
    w_rs1_data = '0;
    w_rs2_data = '0;
    if (w_rs1 != '0) w_rs1_data = (wb_wen_i && (wb_waddr_i == w_rs1)) ? wb_wdata_i : reg1_rdata_i;
    if (w_rs2 != '0) w_rs2_data = (wb_wen_i && (wb_waddr_i == w_rs2)) ? wb_wdata_i : reg2_rdata_i;
    case (w_imm_sel)
      C_IMM_I: w_imm32 = {{20{if_inst_i[31]}}, if_inst_i[31:20]};
      C_IMM_S: w_imm32 = {{20{if_inst_i[31]}}, if_inst_i[31:25], if_inst_i[11:7]};
      C_IMM_B: w_imm32 = {{19{if_inst_i[31]}}, if_inst_i[31], if_inst_i[7], if_inst_i[30:25], if_inst_i[11:8], 1'b0};
      C_IMM_U: w_imm32 = {if_inst_i[31:12], 12'b0};
      C_IMM_J: w_imm32 = {{11{if_inst_i[31]}}, if_inst_i[31], if_inst_i[19:12], if_inst_i[20], if_inst_i[30:21], 1'b0};
      default: w_imm32 = 32'b0;
    endcase
    w_imm = XLEN'($signed(w_imm32));
    case (w_op1_sel)
      C_OP1_RS1:  w_op1 = w_rs1_data;
      C_OP1_PC:   w_op1 = XLEN'(if_pc_i);
      C_OP1_ZIMM: w_op1 = XLEN'(if_inst_i[19:15]);
      default:    w_op1 = '0;
    endcase
    case (w_op2_sel)
      C_OP2_RS2: w_op2 = w_rs2_data;
      C_OP2_IMM: w_op2 = w_imm;
      C_OP2_CSR: w_op2 = csr_rdata_i;
      default:   w_op2 = '0;
    endcase
  end

  logic w_hazard, w_accept;
  assign w_hazard = if_valid_i && ex_load_valid_i && (ex_load_rd_i != '0) &&
                    ((w_uses_rs1 && (w_rs1 == ex_load_rd_i)) || (w_uses_rs2 && (w_rs2 == ex_load_rd_i)));

  logic [0:0]         state_q, state_d;
  logic [C_PAY_W-1:0] payload_q, payload_d, w_payload;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  assign ex_valid_o = (state_q == C_ST_FULL);
  assign if_ready_o = (!ex_valid_o || ex_ready_i) && !w_hazard && !flush_i;
  assign w_accept   = if_valid_i && if_ready_o;

  assign w_payload = {w_op1, w_op2, w_imm, if_pc_i, if_inst_i, w_rd, w_reg_wen,
                      CSR_AW'(if_inst_i[31:20]) & {CSR_AW{w_is_csr}}, w_csr_wen,
                      w_is_load, w_is_store, w_is_branch, w_is_jump, w_is_system, w_illegal};

  assign {op1_o, op2_o, imm_o, pc_o, inst_o, rd_o, reg_wen_o, csr_waddr_o, csr_wen_o,
          is_load_o, is_store_o, is_branch_o, is_jump_o, is_system_o, illegal_o} = payload_q;
  assign stall_cnt_o = stall_cnt_q;

  // Output register next-state: flush wins, then accept, then drain
  always_comb begin
    state_d     = state_q;
    payload_d   = payload_q;
    stall_cnt_d = stall_cnt_q;
    if (flush_i) begin
      state_d = C_ST_EMPTY;
    end else if (w_accept) begin
      state_d   = C_ST_FULL;
      payload_d = w_payload;
    end else if ((state_q == C_ST_FULL) && ex_ready_i) begin
      state_d = C_ST_EMPTY;
    end
    if (w_hazard && !flush_i && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // State, payload and stall counter flops
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= C_ST_EMPTY;
      payload_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      payload_q   <= payload_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Directed self-checking bench for decode_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_valid_i, if_ready_o, flush_i;
  logic [31:0] if_inst_i, if_pc_i;
  logic [4:0]  reg1_raddr_o, reg2_raddr_o;
  logic [31:0] reg1_rdata_i, reg2_rdata_i;
  logic [11:0] csr_raddr_o;
  logic [31:0] csr_rdata_i;
  logic        wb_wen_i;
  logic [4:0]  wb_waddr_i;
  logic [31:0] wb_wdata_i;
  logic        ex_load_valid_i;
  logic [4:0]  ex_load_rd_i;
  logic        ex_valid_o, ex_ready_i;
  logic [31:0] op1_o, op2_o, imm_o, pc_o, inst_o;
  logic [4:0]  rd_o;
  logic        reg_wen_o;
  logic [11:0] csr_waddr_o;
  logic        csr_wen_o, is_load_o, is_store_o, is_branch_o, is_jump_o, is_system_o, illegal_o;
  logic [15:0] stall_cnt_o;

  logic [31:0] rf [32];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  assign reg1_rdata_i = rf[reg1_raddr_o];
  assign reg2_rdata_i = rf[reg2_raddr_o];
  assign csr_rdata_i  = 32'h0000_1800;

  decode_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
    .if_inst_i(if_inst_i), .if_pc_i(if_pc_i), .flush_i(flush_i),
    .reg1_raddr_o(reg1_raddr_o), .reg2_raddr_o(reg2_raddr_o),
    .reg1_rdata_i(reg1_rdata_i), .reg2_rdata_i(reg2_rdata_i),
    .csr_raddr_o(csr_raddr_o), .csr_rdata_i(csr_rdata_i),
    .wb_wen_i(wb_wen_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
    .ex_load_valid_i(ex_load_valid_i), .ex_load_rd_i(ex_load_rd_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .op1_o(op1_o), .op2_o(op2_o), .imm_o(imm_o), .pc_o(pc_o), .inst_o(inst_o),
    .rd_o(rd_o), .reg_wen_o(reg_wen_o), .csr_waddr_o(csr_waddr_o), .csr_wen_o(csr_wen_o),
    .is_load_o(is_load_o), .is_store_o(is_store_o), .is_branch_o(is_branch_o),
    .is_jump_o(is_jump_o), .is_system_o(is_system_o), .illegal_o(illegal_o),
    .stall_cnt_o(stall_cnt_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    if_valid_i = 1'b0; if_inst_i = 32'h0000_0013; if_pc_i = '0; flush_i = 1'b0;
    ex_ready_i = 1'b1; ex_load_valid_i = 1'b0; ex_load_rd_i = '0;
    wb_wen_i = 1'b0; wb_waddr_i = '0; wb_wdata_i = '0;
  endtask

  task automatic present(input logic [31:0] inst, input logic [31:0] pc);
    if_valid_i = 1'b1; if_inst_i = inst; if_pc_i = pc;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    present(32'h0050_0093, 32'h100);
    tick(); tick();
    n_chk++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", ex_valid_o); end
    n_chk++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", pc_o); end
    n_chk++; if (op2_o !== 32'h0) begin n_fail++; $display("FAIL reset_op2 got=%h exp=0", op2_o); end
    n_chk++; if (stall_cnt_o !== 16'h0) begin n_fail++; $display("FAIL reset_stall got=%h exp=0", stall_cnt_o); end
    rst_i = 1'b0;
    idle();
    #1;
    n_chk++; if (if_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", if_ready_o); end
  endtask

  task automatic test_decode();
    present(32'h0050_0093, 32'h100);
    #1;
    n_chk++; if (reg2_raddr_o !== 5'd0) begin n_fail++; $display("FAIL dec_raddr2_unused got=%0d exp=0", reg2_raddr_o); end
    tick();
    if_valid_i = 1'b0;
    n_chk++; if (ex_valid_o !== 1'b1) begin n_fail++; $display("FAIL dec_valid got=%b exp=1", ex_valid_o); end
    n_chk++; if (op1_o !== 32'h0) begin n_fail++; $display("FAIL dec_op1 got=%h exp=0", op1_o); end
    n_chk++; if (op2_o !== 32'h5) begin n_fail++; $display("FAIL dec_op2 got=%h exp=5", op2_o); end
    n_chk++; if (rd_o !== 5'd1) begin n_fail++; $display("FAIL dec_rd got=%0d exp=1", rd_o); end
    n_chk++; if (reg_wen_o !== 1'b1) begin n_fail++; $display("FAIL dec_reg_wen got=%b exp=1", reg_wen_o); end
    n_chk++; if (illegal_o !== 1'b0) begin n_fail++; $display("FAIL dec_illegal got=%b exp=0", illegal_o); end
    n_chk++; if (pc_o !== 32'h100) begin n_fail++; $display("FAIL dec_pc got=%h exp=100", pc_o); end
  endtask

  task automatic test_immediate();
    present(32'hFE00_0EE3, 32'h104);
    tick();
    n_chk++; if (imm_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL imm_b got=%h exp=fffffffc", imm_o); end
    n_chk++; if (is_branch_o !== 1'b1) begin n_fail++; $display("FAIL imm_is_branch got=%b exp=1", is_branch_o); end
    n_chk++; if (reg_wen_o !== 1'b0) begin n_fail++; $display("FAIL imm_b_reg_wen got=%b exp=0", reg_wen_o); end
    present(32'h0080_00EF, 32'h100);
    tick();
    if_valid_i = 1'b0;
    n_chk++; if (op1_o !== 32'h100) begin n_fail++; $display("FAIL jal_op1 got=%h exp=100", op1_o); end
    n_chk++; if (op2_o !== 32'h8) begin n_fail++; $display("FAIL jal_op2 got=%h exp=8", op2_o); end
    n_chk++; if (is_jump_o !== 1'b1) begin n_fail++; $display("FAIL jal_is_jump got=%b exp=1", is_jump_o); end
    tick();
    n_chk++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_valid got=%b exp=0", ex_valid_o); end
  endtask

  task automatic test_load_use();
    ex_load_valid_i = 1'b1; ex_load_rd_i = 5'd2;
    present(32'h0011_01B3, 32'h110);
    #1;
    n_chk++; if (if_ready_o !== 1'b0) begin n_fail++; $display("FAIL lu_ready got=%b exp=0", if_ready_o); end
    tick();
    n_chk++; if (stall_cnt_o !== 16'd1) begin n_fail++; $display("FAIL lu_stall got=%0d exp=1", stall_cnt_o); end
    n_chk++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL lu_no_valid got=%b exp=0", ex_valid_o); end
    ex_load_valid_i = 1'b0;
    #1;
    n_chk++; if (if_ready_o !== 1'b1) begin n_fail++; $display("FAIL lu_ready_clear got=%b exp=1", if_ready_o); end
    tick();
    n_chk++; if (rd_o !== 5'd3) begin n_fail++; $display("FAIL lu_rd got=%0d exp=3", rd_o); end
    n_chk++; if (op1_o !== 32'h1002) begin n_fail++; $display("FAIL lu_op1 got=%h exp=1002", op1_o); end
    n_chk++; if (op2_o !== 32'h1001) begin n_fail++; $display("FAIL lu_op2 got=%h exp=1001", op2_o); end
    // rs2 field of addi x1,x0,5 is 5 but unused: no hazard
    ex_load_valid_i = 1'b1; ex_load_rd_i = 5'd5;
    present(32'h0050_0093, 32'h114);
    #1;
    n_chk++; if (if_ready_o !== 1'b1) begin n_fail++; $display("FAIL lu_unused_rs_ready got=%b exp=1", if_ready_o); end
    tick();
    ex_load_valid_i = 1'b0; if_valid_i = 1'b0;
    n_chk++; if (stall_cnt_o !== 16'd1) begin n_fail++; $display("FAIL lu_unused_rs_stall got=%0d exp=1", stall_cnt_o); end
    tick();
  endtask

  task automatic test_bypass();
    wb_wen_i = 1'b1; wb_waddr_i = 5'd5; wb_wdata_i = 32'hDEAD;
    present(32'h0002_8333, 32'h120);
    tick();
    n_chk++; if (op1_o !== 32'hDEAD) begin n_fail++; $display("FAIL byp_op1 got=%h exp=dead", op1_o); end
    n_chk++; if (op2_o !== 32'h0) begin n_fail++; $display("FAIL byp_x0_op2 got=%h exp=0", op2_o); end
    wb_waddr_i = 5'd0; wb_wdata_i = 32'hFFFF;
    present(32'h0000_0333, 32'h124);
    tick();
    n_chk++; if (op1_o !== 32'h0) begin n_fail++; $display("FAIL byp_x0_op1 got=%h exp=0", op1_o); end
    wb_wen_i = 1'b0; if_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_backpressure_flush();
    present(32'h0050_0093, 32'h200);
    tick();
    ex_ready_i = 1'b0;
    present(32'hFE00_0EE3, 32'h300);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++; if (if_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got=%b exp=0", k, if_ready_o); end
      tick();
      n_chk++; if (pc_o !== 32'h200 || op2_o !== 32'h5 || ex_valid_o !== 1'b1)
        begin n_fail++; $display("FAIL bp_hold[%0d] got pc=%h op2=%h v=%b exp pc=200 op2=5 v=1", k, pc_o, op2_o, ex_valid_o); end
    end
    flush_i = 1'b1;
    #1;
    n_chk++; if (if_ready_o !== 1'b0) begin n_fail++; $display("FAIL fl_ready got=%b exp=0", if_ready_o); end
    tick();
    n_chk++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL fl_valid got=%b exp=0", ex_valid_o); end
    ex_load_valid_i = 1'b1; ex_load_rd_i = 5'd2;
    present(32'h0011_01B3, 32'h310);
    tick();
    n_chk++; if (stall_cnt_o !== 16'd1) begin n_fail++; $display("FAIL fl_hazard_stall got=%0d exp=1", stall_cnt_o); end
    idle();
  endtask

  task automatic test_back_to_back();
    present(32'h0050_0093, 32'h400);
    tick();
    n_chk++; if (pc_o !== 32'h400) begin n_fail++; $display("FAIL b2b_pc0 got=%h exp=400", pc_o); end
    if_pc_i = 32'h404;
    #1;
    n_chk++; if (if_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got=%b exp=1", if_ready_o); end
    tick();
    n_chk++; if (ex_valid_o !== 1'b1 || pc_o !== 32'h404)
      begin n_fail++; $display("FAIL b2b_pc1 got v=%b pc=%h exp v=1 pc=404", ex_valid_o, pc_o); end
    if_valid_i = 1'b0;
    tick();
    n_chk++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got=%b exp=0", ex_valid_o); end
  endtask

  task automatic test_illegal_csr();
    present(32'hFFFF_FFFF, 32'h500);
    tick();
    n_chk++; if (illegal_o !== 1'b1 || reg_wen_o !== 1'b0)
      begin n_fail++; $display("FAIL ill_ones got ill=%b wen=%b exp ill=1 wen=0", illegal_o, reg_wen_o); end
    present(32'h3000_20F3, 32'h504);
    #1;
    n_chk++; if (csr_raddr_o !== 12'h300) begin n_fail++; $display("FAIL csr_raddr got=%h exp=300", csr_raddr_o); end
    tick();
    n_chk++; if (csr_wen_o !== 1'b0 || reg_wen_o !== 1'b1)
      begin n_fail++; $display("FAIL csrrs_x0 got cw=%b rw=%b exp cw=0 rw=1", csr_wen_o, reg_wen_o); end
    n_chk++; if (op2_o !== 32'h1800 || csr_waddr_o !== 12'h300)
      begin n_fail++; $display("FAIL csrrs_op2 got op2=%h wa=%h exp op2=1800 wa=300", op2_o, csr_waddr_o); end
    present(32'h3001_9173, 32'h508);
    tick();
    n_chk++; if (op1_o !== 32'h1003 || csr_wen_o !== 1'b1 || reg_wen_o !== 1'b1)
      begin n_fail++; $display("FAIL csrrw got op1=%h cw=%b rw=%b exp op1=1003 cw=1 rw=1", op1_o, csr_wen_o, reg_wen_o); end
    present(32'h3002_E073, 32'h50C);
    tick();
    n_chk++; if (op1_o !== 32'h5 || csr_wen_o !== 1'b1 || reg_wen_o !== 1'b0)
      begin n_fail++; $display("FAIL csrrsi got op1=%h cw=%b rw=%b exp op1=5 cw=1 rw=0", op1_o, csr_wen_o, reg_wen_o); end
    present(32'h4011_11B3, 32'h510);
    tick();
    n_chk++; if (illegal_o !== 1'b1 || reg_wen_o !== 1'b0)
      begin n_fail++; $display("FAIL ill_f7 got ill=%b wen=%b exp ill=1 wen=0", illegal_o, reg_wen_o); end
    if_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    ex_ready_i = 1'b0;
    present(32'h0050_0093, 32'h600);
    tick();
    if_valid_i = 1'b0;
    n_chk++; if (ex_valid_o !== 1'b1) begin n_fail++; $display("FAIL rm_full got=%b exp=1", ex_valid_o); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_chk++; if (ex_valid_o !== 1'b0 || pc_o !== 32'h0 || stall_cnt_o !== 16'h0)
      begin n_fail++; $display("FAIL rm_cleared got v=%b pc=%h st=%0d exp v=0 pc=0 st=0", ex_valid_o, pc_o, stall_cnt_o); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[0] = 32'hBAD0;
    rf[5] = 32'h0;
    idle();
    test_reset();
    test_decode();
    test_immediate();
    test_load_use();
    test_bypass();
    test_backpressure_flush();
    test_back_to_back();
    test_illegal_csr();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised instruction-decode stage for the RV32I core, placed between IF and EX.
- Decodes the full RV32I base set plus Zicsr and flags illegal encodings.
- Generates format-correct sign-extended immediates and selects operands, with write-back bypass.
- Detects load-use hazards, holds one decoded instruction in an output register under valid/ready handshakes, and counts hazard stalls.

Parameters:
- XLEN, 32, data/operand width (32 only for RV32I encodings; immediates sign-extend to XLEN)
- PC_W, 32, instruction address width
- REG_AW, 5, register address width
- CSR_AW, 12, CSR address width
- CNT_W, 16, stall counter width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- if_valid_i  in  1  instruction valid from IF
- if_ready_o  out  1  stage accepts instruction this cycle
- if_inst_i  in  32  instruction
- if_pc_i  in  PC_W  instruction address
- flush_i  in  1  kill held and incoming instruction
- reg1_raddr_o / reg2_raddr_o  out  REG_AW  combinational regfile read addresses
- reg1_rdata_i / reg2_rdata_i  in  XLEN  same-cycle regfile data
- csr_raddr_o  out  CSR_AW  combinational CSR read address
- csr_rdata_i  in  XLEN  same-cycle CSR data
- wb_wen_i, wb_waddr_i (REG_AW), wb_wdata_i (XLEN)  in  write-back port, used for bypass
- ex_load_valid_i  in  1  load currently in EX
- ex_load_rd_i  in  REG_AW  destination of that load
- ex_valid_o  out  1  decoded instruction valid
- ex_ready_i  in  1  EX accepts
- op1_o, op2_o, imm_o  out  XLEN  operands, immediate
- pc_o  out  PC_W; inst_o  out  32
- rd_o  out  REG_AW; reg_wen_o  out  1
- csr_waddr_o  out  CSR_AW; csr_wen_o  out  1
- is_load_o, is_store_o, is_branch_o, is_jump_o, is_system_o, illegal_o  out  1 each
- stall_cnt_o  out  CNT_W  load-use stall cycles, saturating

Behaviour:
- Decode: combinational from if_inst_i. Read addresses are driven as soon as the format uses rs1/rs2, otherwise 0. csr_raddr_o = inst[31:20] for CSR ops, otherwise 0.
- Bypass: if wb_wen_i and wb_waddr_i == rsN and rsN != 0, use wb_wdata_i for operand N; otherwise use regfile data. Register x0 always reads 0.
- Immediates:
  - I: sext(inst[31:20])
  - S: sext({inst[31:25], inst[11:7]})
  - B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 0})
  - U: {inst[31:12], 12'b0}
  - J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 0})
- Operand selection:
  - R: rs1, rs2.
  - I-ALU / load: rs1, I-imm.
  - Store / branch: rs1, rs2, with imm_o = S-imm / B-imm.
  - JAL: pc, J-imm.
  - JALR: rs1, I-imm.
  - LUI: 0, U-imm.
  - AUIPC: pc, U-imm.
  - CSR: op1 = rs1 data (or zero-extended zimm inst[19:15] for the I variants), op2 = csr_rdata_i.
  - FENCE: no writes, no flags.
- Write enables:
  - reg_wen_o = 1 for R, I, load, JAL, JALR, LUI, AUIPC, CSR; forced 0 when rd == 0.
  - csr_wen_o = 1 for CSRRW/CSRRWI; for CSRRS/CSRRC/CSRRSI/CSRRCI only when rs1/zimm != 0.
- System: func3 = 0 under the SYSTEM opcode sets is_system_o with no writes.
- Illegal: any of the following sets illegal_o = 1 and forces both write enables to 0; the instruction still passes downstream.
  - unknown opcode
  - R-type func7 not 0x00/0x20, or 0x20 with func3 other than ADD/SRL
  - SLLI with func7 != 0; SRLI/SRAI with func7 not 0x00/0x20
  - load func3 3, 6 or 7; store func3 > 2; branch func3 2 or 3
  - JALR func3 != 0
  - SYSTEM func3 = 4
  - inst[1:0] != 2'b11
- Hazard: hazard = if_valid_i & ex_load_valid_i & (ex_load_rd_i != 0) & (a used rs1 or rs2 equals ex_load_rd_i).
- Ready: if_ready_o = (!ex_valid_o | ex_ready_i) & !hazard & !flush_i.
- Output register, two states:
  - EMPTY -> FULL on accept (if_valid_i & if_ready_o).
  - FULL -> FULL on accept with ex_ready_i (back-to-back, zero bubble).
  - FULL -> EMPTY on ex_ready_i with no accept.
  - While FULL and !ex_ready_i, all outputs are held stable.
  - Latency: 1 cycle from accept to ex_valid_o.
- Flush: flush_i empties the register next cycle, overriding accept and handshake. Flush and hazard together do not increment the stall counter.
- Stall counter: increments by 1 each cycle hazard & !flush_i; saturates at all-ones.
- Reset: ex_valid_o = 0 and all registered outputs = 0, including stall_cnt_o. A reset asserted mid-handshake drops the held instruction.

Test Plan:
- Decode: accept 0x00500093 (addi x1, x0, 5) at pc 0x100 -> next cycle ex_valid_o = 1, op1 = 0, op2 = 5, rd = 1, reg_wen = 1, illegal = 0.
- Immediate: 0xFE000EE3 (beq x0, x0, -4) -> imm_o = 0xFFFFFFFC, is_branch = 1, reg_wen = 0.
- Load-use: ex_load_valid_i = 1, rd = 2; add x3, x2, x1 presented -> if_ready_o = 0 for that cycle, stall_cnt_o = 1; accepted once the load clears.
- Bypass: wb writes x5 = 0xDEAD while regfile returns 0 for x5; add x6, x5, x0 -> op1_o = 0xDEAD.
- Back-pressure and flush: hold ex_ready_i = 0 for 3 cycles -> outputs stable, if_ready_o = 0; then assert flush_i -> ex_valid_o = 0 next cycle.
- Illegal and CSR: 0xFFFFFFFF -> illegal_o = 1, reg_wen = 0; csrrs x1, 0x300, x0 -> csr_wen = 0, reg_wen = 1, csr_raddr_o = 0x300.
